// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/md_absval.sv
// Magnitude and sign of a 32-bit operand; unsigned mode passes the value through.
module md_absval
    import muldiv_pkg::*;
(
    input  logic [W-1:0] val,
    input  logic         is_signed,
    output logic [W-1:0] mag,
    output logic         neg
);

    assign neg = is_signed & val[W-1];
    assign mag = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/muldiv.sv
// Iterative 32-bit multiply (shift-add) and divide (restoring), one bit per cycle.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] md_a,
    input  logic [N-1:0] md_b,
    input  logic [1:0]   md_op,
    input  logic         md_start,
    output logic         md_busy,
    output logic         md_done,
    output logic         div_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    state_e         state, state_nxt;
    logic [4:0]     cnt;
    logic [W-1:0]   opnd_r;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [W-1:0]   acc_hi;     // product high / partial remainder
    logic [W-1:0]   acc_lo;     // multiplier bits / quotient being built
    logic           neg_a_r, neg_b_r;
    logic [W-1:0]   hi_r, lo_r;
    logic           dz_r;

    logic [W-1:0]   a_w, b_w, mag_a, mag_b;
    logic           neg_a, neg_b;
    logic           is_div, start_ok, div0_in, last;
    logic           unused_upper;

    assign a_w          = md_a[W-1:0];
    assign b_w          = md_b[W-1:0];
    assign unused_upper = ^{md_a[N-1:W], md_b[N-1:W]};
    assign is_div       = md_op[1];
    assign start_ok     = md_start && (state == S_IDLE || state == S_DONE);
    assign div0_in      = is_div && (b_w == '0);
    assign last         = (cnt == 5'd31);

    md_absval u_abs_a (.val(a_w), .is_signed(md_op[0]), .mag(mag_a), .neg(neg_a));
    md_absval u_abs_b (.val(b_w), .is_signed(md_op[0]), .mag(mag_b), .neg(neg_b));

    // One iteration step for whichever operation is running
    logic [W:0]     mul_sum, div_shift;
    logic [W-1:0]   div_diff, step_hi, step_lo;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // Datapath step and final sign correction
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_r} : '0);
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift[W-1:0] - opnd_r;
        step_hi   = '0;
        step_lo   = '0;
        if (state == S_DIV) begin
            if (div_shift >= {1'b0, opnd_r}) begin
                step_hi = div_diff;
                step_lo = {acc_lo[W-2:0], 1'b1};
            end else begin
                step_hi = div_shift[W-1:0];
                step_lo = {acc_lo[W-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo[W-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = (neg_a_r ^ neg_b_r) ? (~prod + 64'd1) : prod;
        quo_fix  = (neg_a_r ^ neg_b_r) ? (~step_lo + 1'b1) : step_lo;
        rem_fix  = neg_a_r ? (~step_hi + 1'b1) : step_hi;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        md_busy   = 1'b0;
        md_done   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                md_done = (state == S_DONE);
                if (md_start) begin
                    if (!is_div)      state_nxt = S_MUL;
                    else if (div0_in) state_nxt = S_DONE;
                    else              state_nxt = S_DIV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                md_busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration registers and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            opnd_r  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            dz_r    <= 1'b0;
        end else if (start_ok) begin
            cnt     <= '0;
            opnd_r  <= is_div ? mag_b : mag_a;
            acc_hi  <= '0;
            acc_lo  <= is_div ? mag_a : mag_b;
            neg_a_r <= neg_a;
            neg_b_r <= neg_b;
            if (div0_in) begin
                hi_r <= a_w;
                lo_r <= '1;
                dz_r <= 1'b1;
            end
        end else if (state == S_MUL || state == S_DIV) begin
            cnt    <= cnt + 5'd1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last) begin
                dz_r <= 1'b0;
                if (state == S_MUL) begin
                    hi_r <= prod_fix[2*W-1:W];
                    lo_r <= prod_fix[W-1:0];
                end else begin
                    hi_r <= rem_fix;
                    lo_r <= quo_fix;
                end
            end
        end
    end

    assign div_zero = dz_r;
    assign hi       = {{(N-W){1'b0}}, hi_r};
    assign lo       = {{(N-W){1'b0}}, lo_r};

endmodule
